// File: rtl/trigger_coinc_gen.sv
// trigger_coinc_gen
//
// Multi-channel coincidence trigger generator for the TDC readout, clocked on
// SYSCLK. A new hit on a channel is seen as any change of that channel's hit
// counter. Each change opens a per-channel coincidence window. When enough
// enabled channels have open windows at the same time, TRIGGER fires. TRIGGER
// is then stretched to a programmable width and followed by a dead time. The
// block counts issued triggers and latches the channel pattern that caused the
// last one.
//
// Optional feature macro: TRIGGER_RETRIG_EN
//   When defined, a hit on any enabled channel during FIRE reloads the hold
//   counter, so the pulse extends past the last hit. The pattern ORs in the
//   new active bits, and the trigger counter is left alone.
//   When undefined, FIRE always lasts exactly max(holdLen,1) cycles.
//
// Ports
//   SYSCLK      system clock, the only clock
//   RESET       asynchronous active-high reset
//   hitCount    packed per-channel hit counters, channel i at [i*CW +: CW]
//   chMask      per-channel enable; 1 = channel participates
//   minCoinc    minimum coincident channels (0 behaves as 1)
//   coincWin    coincidence window in cycles (0 behaves as 1)
//   holdLen     TRIGGER high time in cycles (0 behaves as 1)
//   deadLen     dead time after TRIGGER in cycles (0 = none)
//   TRIGGER     registered trigger output
//   busy        high while in FIRE or DEAD
//   trigCount   triggers issued, wraps modulo 2^32
//   trigPattern active-channel set latched when a trigger fires
module trigger_coinc_gen #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int TW  = 8,
  parameter int NW  = $clog2(NCH + 1)
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic [NCH*CW-1:0] hitCount,
  input  logic [NCH-1:0]    chMask,
  input  logic [NW-1:0]     minCoinc,
  input  logic [TW-1:0]     coincWin,
  input  logic [TW-1:0]     holdLen,
  input  logic [TW-1:0]     deadLen,
  output logic              TRIGGER,
  output logic              busy,
  output logic [31:0]       trigCount,
  output logic [NCH-1:0]    trigPattern
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [TW-1:0] ONE_TW = TW'(1);

  logic [CW-1:0]   prevCnt_q [NCH];
  logic            primed_q;
  logic [TW-1:0]   win_q [NCH];
  logic [TW-1:0]   win_d [NCH];
  logic [NCH-1:0]  chg;
  logic [NCH-1:0]  active;
  logic [NW-1:0]   activeCnt;
  logic [TW-1:0]   effWin;
  logic [TW-1:0]   effHold;
  logic [NW-1:0]   effMin;
  logic            cond;
  state_t          state_q, state_d;
  logic [TW-1:0]   holdCnt_q, holdCnt_d;
  logic [TW-1:0]   deadCnt_q, deadCnt_d;
  logic [31:0]     trigCount_q, trigCount_d;
  logic [NCH-1:0]  trigPattern_q, trigPattern_d;
  logic            trigger_q;
`ifdef TRIGGER_RETRIG_EN
  logic [NCH-1:0]  activeNext;
`endif

  // Zero-valued length settings behave as 1 so a window or pulse always
  // lasts at least one cycle.
  assign effWin  = (coincWin == '0) ? ONE_TW : coincWin;
  assign effHold = (holdLen == '0) ? ONE_TW : holdLen;
  assign effMin  = (minCoinc == '0) ? NW'(1) : minCoinc;

  // Change detection and window bookkeeping. A channel counts as active while
  // its window is open and it is still enabled, so clearing a mask bit takes
  // effect at once. Any counter difference, including wrap or multi-count
  // jumps, is a single event. Nothing is detected until the first post-reset
  // edge has captured the counters.
  always_comb begin
    chg       = '0;
    active    = '0;
    activeCnt = '0;
`ifdef TRIGGER_RETRIG_EN
    activeNext = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      win_d[i] = '0;
      chg[i]   = primed_q & chMask[i] & (hitCount[i*CW +: CW] != prevCnt_q[i]);
      if (chg[i]) begin
        win_d[i] = effWin;
      end else if (win_q[i] != '0) begin
        win_d[i] = win_q[i] - ONE_TW;
      end
      active[i] = (win_q[i] != '0) & chMask[i];
      activeCnt = activeCnt + NW'(active[i]);
`ifdef TRIGGER_RETRIG_EN
      activeNext[i] = (win_d[i] != '0) & chMask[i];
`endif
    end
  end

  // A popcount of at most NCH can never reach a threshold above NCH, so an
  // oversized minCoinc simply never fires.
  assign cond = (activeCnt >= effMin);

  // Counter capture and window registers. The counters are recorded on every
  // edge, including the priming edge, so a nonzero count at reset is
  // absorbed rather than treated as a hit.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      primed_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        prevCnt_q[i] <= '0;
        win_q[i]     <= '0;
      end
    end else begin
      primed_q <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        prevCnt_q[i] <= hitCount[i*CW +: CW];
        win_q[i]     <= win_d[i];
      end
    end
  end

  // Trigger FSM next-state logic. Hold and dead lengths are sampled only when
  // their counters load, so a change mid-pulse applies to the next pulse.
  // Windows keep running in FIRE and DEAD; if the condition still holds on
  // return to IDLE, the next trigger fires one edge later.
  always_comb begin
    state_d       = state_q;
    holdCnt_d     = holdCnt_q;
    deadCnt_d     = deadCnt_q;
    trigCount_d   = trigCount_q;
    trigPattern_d = trigPattern_q;
    case (state_q)
      IDLE: begin
        if (cond) begin
          state_d       = FIRE;
          holdCnt_d     = effHold;
          trigCount_d   = trigCount_q + 32'd1;
          trigPattern_d = active;
        end
      end
      FIRE: begin
`ifdef TRIGGER_RETRIG_EN
        if (|chg) begin
          holdCnt_d     = effHold;
          trigPattern_d = trigPattern_q | activeNext;
        end else
`endif
        if (holdCnt_q <= ONE_TW) begin
          if (deadLen != '0) begin
            state_d   = DEAD;
            deadCnt_d = deadLen;
          end else begin
            state_d = IDLE;
          end
        end else begin
          holdCnt_d = holdCnt_q - ONE_TW;
        end
      end
      DEAD: begin
        if (deadCnt_q <= ONE_TW) begin
          state_d = IDLE;
        end else begin
          deadCnt_d = deadCnt_q - ONE_TW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and output registers. TRIGGER is registered from the next
  // state so it rises on the same edge that trigCount and trigPattern update.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      holdCnt_q     <= '0;
      deadCnt_q     <= '0;
      trigCount_q   <= '0;
      trigPattern_q <= '0;
      trigger_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      holdCnt_q     <= holdCnt_d;
      deadCnt_q     <= deadCnt_d;
      trigCount_q   <= trigCount_d;
      trigPattern_q <= trigPattern_d;
      trigger_q     <= (state_d == FIRE);
    end
  end

  assign TRIGGER     = trigger_q;
  assign busy        = (state_q != IDLE);
  assign trigCount   = trigCount_q;
  assign trigPattern = trigPattern_q;

endmodule

// File: doc/trigger_coinc_gen.md
# trigger_coinc_gen

Multi-channel trigger generator for the TDC readout, clocked on SYSCLK (192 MHz PLL output). It watches the per-channel hit counters published by the data channels and detects new hits as count changes. A trigger fires when a programmable number of enabled channels see hits within a coincidence window. TRIGGER is stretched to a programmable width, followed by a dead time, and the block keeps a trigger counter and the channel pattern that caused the last trigger.

## Interface
Parameters:
- NCH, 4: number of channels (1..16)
- CW, 32: width of each hit counter
- TW, 8: width of the window, hold and dead-time length inputs
- NW, $clog2(NCH+1): width of minCoinc

Ports:
- SYSCLK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- hitCount  in  NCH*CW  packed hit counters; channel i at [i*CW +: CW]; synchronous to SYSCLK
- chMask  in  NCH  1 = channel participates
- minCoinc  in  NW  minimum number of coincident channels; 0 treated as 1
- coincWin  in  TW  coincidence window in cycles; 0 treated as 1
- holdLen  in  TW  TRIGGER high time in cycles; 0 treated as 1
- deadLen  in  TW  dead time after TRIGGER in cycles; 0 = none
- TRIGGER  out  1  trigger output, registered
- busy  out  1  high in FIRE or DEAD
- trigCount  out  32  number of triggers issued; wraps modulo 2^32
- trigPattern  out  NCH  active-channel set latched at fire

## Operation
- Reset: all outputs 0, state IDLE, all prevCnt/win registers 0, primed = 0.
- Priming:
  - On the first edge after reset release, load prevCnt[i] = hitCount[i] with no change detection, then set primed = 1.
  - A nonzero counter at reset therefore does not cause a trigger.
- Change detect: chg[i] = primed & chMask[i] & (hitCount[i] != prevCnt[i]). prevCnt[i] updates every edge.
  - Any difference counts as one event, including counter wrap and multi-count jumps.
- Window:
  - chg[i] reloads win[i] = max(coincWin,1).
  - Otherwise win[i] decrements to 0 and holds there.
  - active[i] = (win[i] != 0) & chMask[i].
  - Clearing chMask[i] masks the channel immediately.
- Condition: cond = popcount(active) >= max(minCoinc,1). If minCoinc > NCH, the block never fires.
- FSM:
  - IDLE: if cond, go to FIRE; load hold counter = max(holdLen,1); trigCount += 1; trigPattern = active.
  - FIRE: TRIGGER = 1; decrement the hold counter. On reaching 1, go to DEAD if deadLen != 0 (load dead counter = deadLen), else go to IDLE.
  - DEAD: TRIGGER = 0; decrement the dead counter; go to IDLE after deadLen cycles.
- Events arriving in FIRE or DEAD still refresh the windows, but do not start a new trigger until IDLE is reached.
  - If cond is still true on entry to IDLE, the next trigger fires on the following edge.
- Length inputs are sampled only when their counter loads; changes mid-pulse take effect at the next load.

## Timing
- New count sampled at edge k: win loaded at edge k; state = FIRE and TRIGGER = 1 after edge k+1.
  - Latency is 1 cycle from the sampling edge.
- TRIGGER stays high exactly max(holdLen,1) cycles, then low for deadLen cycles minimum.
  - Minimum trigger period = max(holdLen,1) + deadLen + 1 cycles.
- Channels whose changes are sampled up to coincWin-1 edges apart are coincident.
  - Example: coincWin = 3 accepts a spread of up to 2 cycles.
- Simultaneous changes on several channels at the same edge count individually toward minCoinc.
- trigCount and trigPattern update on the same edge that TRIGGER rises.
- RESET mid-pulse: TRIGGER and busy drop asynchronously. Priming repeats after release.

## Configuration
- TRIGGER_RETRIG_EN defined: in FIRE, a chg on any enabled channel reloads the hold counter, so TRIGGER extends to max(holdLen,1) cycles after the last hit.
  - trigCount does not increment on a retrigger.
  - trigPattern ORs in the new active bits.
  - With NCH=1, minCoinc=1, holdLen=255, deadLen=0 this reproduces the legacy single-channel 255-cycle stretcher.
- Undefined: FIRE length is fixed at max(holdLen,1); hits during FIRE only refresh windows.

## Test plan
- NCH=4, mask=4'b0001, minCoinc=1, holdLen=5, deadLen=0; hitCount0 0->1 at edge 10 -> TRIGGER high after edges 11..15 (5 cycles), trigCount=1, trigPattern=4'b0001.
- minCoinc=2, coincWin=3; ch0 changes at edge 10, ch2 at edge 12 -> fire after edge 13, pattern 4'b0101. Repeat with ch2 at edge 13 -> no trigger.
- hitCount0=0xFFFFFFFF at reset release -> no trigger. Later 0xFFFFFFFF->0x0 wrap -> one trigger.
- holdLen=4, deadLen=10; ch0 toggles every 3 cycles for 60 cycles -> triggers start 15 cycles apart. With TRIGGER_RETRIG_EN, TRIGGER is continuously high, trigCount=1.
- RESET asserted while TRIGGER high -> TRIGGER, busy, trigCount, trigPattern all 0 without waiting for a clock edge. First post-release edge produces no trigger.
- mask=4'b0000 with all channels toggling -> TRIGGER stays 0, trigCount=0.
